level_walker: RTL and testbench

- Traversal controller for one `level` stage.
- A level's memory holds a binary search tree of words; each entry has left/right pointers with valid bits. The level answers one node comparison per access.
- This block takes a lookup key and a root pointer, usually the previous level's result. It repeatedly drives `address_in`/`lookup_cont_in` of its level and follows `next_pointer_out` until a match, a missing child, or a step limit.
- It returns a single result per request over a valid/ready handshake, for the next level or for the FIB result logic.

---
 rtl/level_walker.sv | 163 ++++++++++++++++
 tb/tb_level_walker.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/level_walker.sv
// Walks one level's binary search tree: drives a node address, waits out the
// level's read latency, then follows the returned child pointer until the key matches, a child is missing, or the step limit is reached.
module level_walker #(
  parameter int WORD_SIZE     = 16,
  parameter int POINTER_SIZE  = 16,
  parameter int MAX_STEPS     = 16,
  parameter int STEP_W        = 5,
  parameter int LEVEL_LATENCY = 1
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    req_valid_in,
  output logic                    req_ready_out,
  input  logic [WORD_SIZE-1:0]    req_key_in,
  input  logic [POINTER_SIZE-1:0] req_root_in,
  output logic [POINTER_SIZE-1:0] lvl_address_out,
  output logic [WORD_SIZE-1:0]    lvl_lookup_cont_out,
  input  logic [POINTER_SIZE-1:0] lvl_next_pointer_in,
  input  logic                    lvl_is_match_in,
  input  logic                    lvl_no_child_in,
  output logic                    rsp_valid_out,
  input  logic                    rsp_ready_in,
  output logic                    rsp_hit_out,
  output logic                    rsp_timeout_out,
  output logic [POINTER_SIZE-1:0] rsp_node_out,
  output logic [STEP_W-1:0]       rsp_steps_out
);

  localparam int WAIT_W = (LEVEL_LATENCY < 1) ? 1 : $clog2(LEVEL_LATENCY + 1);
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(LEVEL_LATENCY);
  localparam logic [STEP_W-1:0] STEP_MAX  = STEP_W'(MAX_STEPS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [WAIT_W-1:0]       wait_q, wait_d;
  logic [STEP_W-1:0]       visits_q, visits_d;
  logic                    ready_q, ready_d;
  logic [POINTER_SIZE-1:0] addr_q, addr_d;
  logic [WORD_SIZE-1:0]    cont_q, cont_d;
  logic                    valid_q, valid_d;
  logic                    hit_q, hit_d;
  logic                    timeout_q, timeout_d;
  logic [POINTER_SIZE-1:0] node_q, node_d;
  logic [STEP_W-1:0]       steps_q, steps_d;

  // Visit count saturates at the step limit instead of wrapping.
  function automatic logic [STEP_W-1:0] sat_inc(input logic [STEP_W-1:0] v);
    return (v >= STEP_MAX) ? v : v + STEP_W'(1);
  endfunction

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    visits_d  = visits_q;
    ready_d   = ready_q;
    addr_d    = addr_q;
    cont_d    = cont_q;
    valid_d   = valid_q;
    hit_d     = hit_q;
    timeout_d = timeout_q;
    node_d    = node_q;
    steps_d   = steps_q;
    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (req_valid_in) begin
          cont_d   = req_key_in;
          addr_d   = req_root_in;
          visits_d = STEP_W'(1);
          wait_d   = WAIT_LOAD;
          ready_d  = 1'b0;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (wait_q != '0) begin
          wait_d = wait_q - WAIT_W'(1);
        end else if (lvl_is_match_in) begin
          // The level's pointer output is stale on a match, so it is not used.
          hit_d     = 1'b1;
          timeout_d = 1'b0;
          node_d    = addr_q;
          steps_d   = visits_q;
          valid_d   = 1'b1;
          state_d   = RESP;
        end else if (lvl_no_child_in) begin
          hit_d     = 1'b0;
          timeout_d = 1'b0;
          node_d    = addr_q;
          steps_d   = visits_q;
          valid_d   = 1'b1;
          state_d   = RESP;
        end else if (visits_q == STEP_MAX) begin
          hit_d     = 1'b0;
          timeout_d = 1'b1;
          node_d    = addr_q;
          steps_d   = visits_q;
          valid_d   = 1'b1;
          state_d   = RESP;
        end else begin
          addr_d   = lvl_next_pointer_in;
          visits_d = sat_inc(visits_q);
          wait_d   = WAIT_LOAD;
        end
      end
      RESP: begin
        if (rsp_ready_in) begin
          valid_d = 1'b0;
          ready_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= IDLE;
      wait_q    <= '0;
      visits_q  <= '0;
      ready_q   <= 1'b1;
      addr_q    <= '0;
      cont_q    <= '0;
      valid_q   <= 1'b0;
      hit_q     <= 1'b0;
      timeout_q <= 1'b0;
      node_q    <= '0;
      steps_q   <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      visits_q  <= visits_d;
      ready_q   <= ready_d;
      addr_q    <= addr_d;
      cont_q    <= cont_d;
      valid_q   <= valid_d;
      hit_q     <= hit_d;
      timeout_q <= timeout_d;
      node_q    <= node_d;
      steps_q   <= steps_d;
    end
  end

  assign req_ready_out       = ready_q;
  assign lvl_address_out     = addr_q;
  assign lvl_lookup_cont_out = cont_q;
  assign rsp_valid_out       = valid_q;
  assign rsp_hit_out         = hit_q;
  assign rsp_timeout_out     = timeout_q;
  assign rsp_node_out        = node_q;
  assign rsp_steps_out       = steps_q;

endmodule

// File: tb/tb_level_walker.sv
// Bench for level_walker: a one-cycle-latency level model over a fixed
// four-node tree, a tree-walk reference model, and directed lookups.
module tb_level_walker;

  typedef struct packed {
    logic        hit;
    logic        to;
    logic [15:0] node;
    logic [4:0]  steps;
  } res_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1;

  int checks = 0;
  int errors = 0;

  logic [15:0] t_word [4] = '{16'h0050, 16'h0020, 16'h0080, 16'h0090};
  logic        t_lv   [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
  logic [15:0] t_l    [4] = '{16'd1, 16'd0, 16'd0, 16'd0};
  logic        t_rv   [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  logic [15:0] t_r    [4] = '{16'd2, 16'd0, 16'd3, 16'd0};

  // Instance A: MAX_STEPS = 16
  logic req_valid_a = 0, req_ready_a, rsp_valid_a, rsp_ready_a = 0, hit_a, to_a;
  logic [15:0] key_a = 0, root_a = 0, addr_a, cont_a, node_a;
  logic [15:0] np_a = 0;
  logic m_a = 0, nc_a = 0;
  logic [4:0] steps_a;
  // Instance B: MAX_STEPS = 2
  logic req_valid_b = 0, req_ready_b, rsp_valid_b, rsp_ready_b = 0, hit_b, to_b;
  logic [15:0] key_b = 0, root_b = 0, addr_b, cont_b, node_b;
  logic [15:0] np_b = 0;
  logic m_b = 0, nc_b = 0;
  logic [4:0] steps_b;

  res_t exp_a = '0, exp_b = '0;
  logic b_active = 0;

  level_walker #(.WORD_SIZE(16), .POINTER_SIZE(16), .MAX_STEPS(16), .STEP_W(5),
                 .LEVEL_LATENCY(1)) dut_a (
    .clk_in(clk), .rst_in(rst), .req_valid_in(req_valid_a), .req_ready_out(req_ready_a),
    .req_key_in(key_a), .req_root_in(root_a), .lvl_address_out(addr_a),
    .lvl_lookup_cont_out(cont_a), .lvl_next_pointer_in(np_a), .lvl_is_match_in(m_a),
    .lvl_no_child_in(nc_a), .rsp_valid_out(rsp_valid_a), .rsp_ready_in(rsp_ready_a),
    .rsp_hit_out(hit_a), .rsp_timeout_out(to_a), .rsp_node_out(node_a),
    .rsp_steps_out(steps_a));

  level_walker #(.WORD_SIZE(16), .POINTER_SIZE(16), .MAX_STEPS(2), .STEP_W(5),
                 .LEVEL_LATENCY(1)) dut_b (
    .clk_in(clk), .rst_in(rst), .req_valid_in(req_valid_b), .req_ready_out(req_ready_b),
    .req_key_in(key_b), .req_root_in(root_b), .lvl_address_out(addr_b),
    .lvl_lookup_cont_out(cont_b), .lvl_next_pointer_in(np_b), .lvl_is_match_in(m_b),
    .lvl_no_child_in(nc_b), .rsp_valid_out(rsp_valid_b), .rsp_ready_in(rsp_ready_b),
    .rsp_hit_out(hit_b), .rsp_timeout_out(to_b), .rsp_node_out(node_b),
    .rsp_steps_out(steps_b));

  // Level: {match, no_child, next_pointer}; pointer left stale unless a child is taken.
  function automatic logic [17:0] level_fn(input logic [15:0] a, input logic [15:0] k,
                                           input logic [15:0] old);
    logic [1:0] i;
    i = a[1:0];
    if (a > 16'd3) return {2'b01, old};
    if (k == t_word[i]) return {2'b10, old};
    if (k < t_word[i]) return t_lv[i] ? {2'b00, t_l[i]} : {2'b01, old};
    return t_rv[i] ? {2'b00, t_r[i]} : {2'b01, old};
  endfunction

  always @(posedge clk) begin
    {m_a, nc_a, np_a} <= level_fn(addr_a, cont_a, np_a);
    {m_b, nc_b, np_b} <= level_fn(addr_b, cont_b, np_b);
  end

  // Reference: plain BST descent with a step limit.
  function automatic res_t walk(input logic [15:0] key, input logic [15:0] root,
                                input int max);
    res_t r;
    int node, steps;
    logic cv;
    logic [15:0] cp;
    r = '0;
    node = int'(root);
    steps = 1;
    for (int i = 0; i < 64; i++) begin
      if (key == t_word[node]) begin
        r.hit = 1'b1;
        break;
      end
      cv = (key < t_word[node]) ? t_lv[node] : t_rv[node];
      cp = (key < t_word[node]) ? t_l[node] : t_r[node];
      if (!cv) break;
      if (steps == max) begin
        r.to = 1'b1;
        break;
      end
      node = int'(cp);
      steps++;
    end
    r.node = 16'(node);
    r.steps = 5'(steps);
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rsp_valid_a === 1'b1) begin
      check("a_hit", hit_a, exp_a.hit);
      check("a_timeout", to_a, exp_a.to);
      check("a_node", node_a, exp_a.node);
      check("a_steps", steps_a, exp_a.steps);
      check("a_ready_in_resp", req_ready_a, 0);
    end
    if (rsp_valid_b === 1'b1) begin
      check("b_hit", hit_b, exp_b.hit);
      check("b_timeout", to_b, exp_b.to);
      check("b_node", node_b, exp_b.node);
      check("b_steps", steps_b, exp_b.steps);
    end
    if (b_active) check("b_addr_not3", addr_b == 16'd3, 0);
  end

  task automatic issue(input logic [15:0] key, input logic [15:0] root);
    exp_a = walk(key, root, 16);
    key_a = key;
    root_a = root;
    req_valid_a = 1'b1;
    @(posedge clk); #1;
    req_valid_a = 1'b0;
    check("a_accept_ready", req_ready_a, 0);
    check("a_addr_root", addr_a, root);
    check("a_cont_key", cont_a, key);
  endtask

  task automatic await_rsp(input int lat, input logic hit, input logic to,
                           input logic [15:0] node, input logic [4:0] steps);
    int n;
    n = 0;
    while (rsp_valid_a !== 1'b1 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    check("a_latency", n, lat);
    check("a_lit_hit", hit_a, hit);
    check("a_lit_timeout", to_a, to);
    check("a_lit_node", node_a, node);
    check("a_lit_steps", steps_a, steps);
  endtask

  task automatic accept_a();
    rsp_ready_a = 1'b1;
    @(posedge clk); #1;
    rsp_ready_a = 1'b0;
    check("a_valid_after_accept", rsp_valid_a, 0);
    check("a_ready_after_accept", req_ready_a, 1);
  endtask

  initial begin
    int n;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", rsp_valid_a, 0);
    check("rst_ready", req_ready_a, 1);
    check("rst_addr", addr_a, 0);
    check("rst_cont", cont_a, 0);
    check("rst_hit", hit_a, 0);
    check("rst_timeout", to_a, 0);
    check("rst_node", node_a, 0);
    check("rst_steps", steps_a, 0);
    check("rst_b_ready", req_ready_b, 1);
    rst = 1'b0;

    issue(16'h0050, 16'd0); await_rsp(2, 1, 0, 16'd0, 5'd1); accept_a();
    issue(16'h0090, 16'd0); await_rsp(6, 1, 0, 16'd3, 5'd3); accept_a();
    issue(16'h0010, 16'd0); await_rsp(4, 0, 0, 16'd1, 5'd2); accept_a();

    // Step-limited instance never reaches node 3.
    b_active = 1'b1;
    exp_b = walk(16'h0090, 16'd0, 2);
    key_b = 16'h0090;
    root_b = 16'd0;
    req_valid_b = 1'b1;
    @(posedge clk); #1;
    req_valid_b = 1'b0;
    n = 0;
    while (rsp_valid_b !== 1'b1 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    check("b_latency", n, 4);
    check("b_lit_hit", hit_b, 0);
    check("b_lit_timeout", to_b, 1);
    check("b_lit_node", node_b, 2);
    check("b_lit_steps", steps_b, 2);
    rsp_ready_b = 1'b1;
    @(posedge clk); #1;
    rsp_ready_b = 1'b0;
    check("b_valid_after_accept", rsp_valid_b, 0);
    repeat (3) @(posedge clk);
    #1;
    b_active = 1'b0;

    // Backpressure with a pending request held high.
    issue(16'h0050, 16'd0); await_rsp(2, 1, 0, 16'd0, 5'd1);
    key_a = 16'h0020;
    root_a = 16'd0;
    req_valid_a = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      check("bp_valid", rsp_valid_a, 1);
      check("bp_hit", hit_a, 1);
      check("bp_node", node_a, 0);
      check("bp_steps", steps_a, 1);
      check("bp_ready", req_ready_a, 0);
    end
    rsp_ready_a = 1'b1;
    @(posedge clk); #1;
    rsp_ready_a = 1'b0;
    check("bp_accept_valid", rsp_valid_a, 0);
    check("bp_accept_ready", req_ready_a, 1);
    exp_a = walk(16'h0020, 16'd0, 16);
    @(posedge clk); #1;
    req_valid_a = 1'b0;
    check("bp_next_ready", req_ready_a, 0);
    check("bp_next_addr", addr_a, 0);
    check("bp_next_cont", cont_a, 16'h0020);
    await_rsp(4, 1, 0, 16'd1, 5'd2); accept_a();

    // Reset during WAIT aborts the lookup.
    issue(16'h0090, 16'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_valid", rsp_valid_a, 0);
    check("mid_rst_ready", req_ready_a, 1);
    check("mid_rst_addr", addr_a, 0);
    check("mid_rst_cont", cont_a, 0);
    check("mid_rst_hit", hit_a, 0);
    check("mid_rst_timeout", to_a, 0);
    check("mid_rst_node", node_a, 0);
    check("mid_rst_steps", steps_a, 0);
    repeat (8) begin
      @(posedge clk); #1;
      check("mid_rst_no_rsp", rsp_valid_a, 0);
    end
    issue(16'h0050, 16'd0); await_rsp(2, 1, 0, 16'd0, 5'd1); accept_a();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
